// File: rtl/cache_arbiter_pkg.sv
// Shared types for the cache arbiter: bus widths, FSM state encoding and requester port IDs.
package cache_arbiter_pkg;

  localparam int WIDTH         = 32;
  localparam int MASK_W        = WIDTH / 8;
  localparam int A_STATE_WIDTH = 2;

  typedef enum logic [A_STATE_WIDTH-1:0] {
    A_IDLE  = 2'd0,
    A_ISSUE = 2'd1,
    A_BUSY  = 2'd2,
    A_RESP  = 2'd3
  } arb_state_e;

  localparam logic PORT_IFU = 1'b0;
  localparam logic PORT_LSU = 1'b1;

endpackage

// File: rtl/cache_arbiter_rr_grant.sv
// Two-input grant logic plus priority pointer.
// CACHE_ARB_RR_EN selects round-robin; otherwise RR_INIT is a fixed winner on ties.
module rr_grant
  import cache_arbiter_pkg::*;
#(
  parameter logic RR_INIT = PORT_IFU
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       owner_i,
  output logic       grant_o
);

  logic ptr_q, ptr_d;

`ifdef CACHE_ARB_RR_EN
  // After a completion the other port gets priority, bounding its wait to one transaction.
  always_comb ptr_d = update_i ? ~owner_i : ptr_q;
`else
  logic unused_update;
  assign unused_update = update_i ^ owner_i;
  always_comb ptr_d = ptr_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= RR_INIT;
    else     ptr_q <= ptr_d;
  end

  always_comb begin
    case (req_i)
      2'b01:   grant_o = PORT_IFU;
      2'b10:   grant_o = PORT_LSU;
      default: grant_o = ptr_q;
    endcase
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares a single-ported, level-handshake cache between IFU (port 0) and LSU (port 1).
// Grant policy comes from rr_grant (round-robin when CACHE_ARB_RR_EN is defined).
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter logic RR_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic [WIDTH-1:0]  p0_req_addr,
  input  logic [WIDTH-1:0]  p0_req_data,
  input  logic [MASK_W-1:0] p0_req_mask,
  output logic              p0_resp_valid,
  output logic [WIDTH-1:0]  p0_resp_data,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic [WIDTH-1:0]  p1_req_addr,
  input  logic [WIDTH-1:0]  p1_req_data,
  input  logic [MASK_W-1:0] p1_req_mask,
  output logic              p1_resp_valid,
  output logic [WIDTH-1:0]  p1_resp_data,
  output logic              c_req_valid,
  output logic [WIDTH-1:0]  c_req_addr,
  output logic [WIDTH-1:0]  c_req_data,
  output logic [MASK_W-1:0] c_req_mask,
  input  logic              c_resp_valid,
  input  logic [WIDTH-1:0]  c_resp_data
);

  arb_state_e        state_q, state_d;
  logic              owner_q;
  logic              busy_first_q;
  logic [WIDTH-1:0]  addr_q, data_q, resp_data_q;
  logic [MASK_W-1:0] mask_q;
  logic              grant, accept, capture, update;

  rr_grant #(.RR_INIT(RR_INIT)) u_rr_grant (
    .clk      (clk),
    .rst      (rst),
    .req_i    ({p1_req_valid, p0_req_valid}),
    .update_i (update),
    .owner_i  (owner_q),
    .grant_o  (grant)
  );

  assign accept  = p0_req_ready | p1_req_ready;
  // The cache's idle level lags the request by a cycle, so the first BUSY cycle is ignored.
  assign capture = (state_q == A_BUSY) && !busy_first_q && c_resp_valid;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= A_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      A_IDLE:  if (accept)       state_d = A_ISSUE;
      A_ISSUE: if (c_resp_valid) state_d = A_BUSY;
      A_BUSY:  if (capture)      state_d = A_RESP;
      A_RESP:                    state_d = A_IDLE;
      default:                   state_d = A_IDLE;
    endcase
  end

  always_comb begin
    p0_req_ready  = 1'b0;
    p1_req_ready  = 1'b0;
    p0_resp_valid = 1'b0;
    p1_resp_valid = 1'b0;
    c_req_valid   = 1'b0;
    update        = 1'b0;
    case (state_q)
      A_IDLE: begin
        p0_req_ready = (grant == PORT_IFU) && p0_req_valid;
        p1_req_ready = (grant == PORT_LSU) && p1_req_valid;
      end
      A_ISSUE: c_req_valid = c_resp_valid;
      A_RESP: begin
        p0_resp_valid = (owner_q == PORT_IFU);
        p1_resp_valid = (owner_q == PORT_LSU);
        update        = 1'b1;
      end
      default: ;
    endcase
  end

  // Request fields stay frozen from accept until the next accept; the cache rereads them during refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q      <= PORT_IFU;
      busy_first_q <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      mask_q       <= '0;
      resp_data_q  <= '0;
    end else begin
      busy_first_q <= (state_q == A_ISSUE);
      if (accept) begin
        owner_q <= grant;
        addr_q  <= (grant == PORT_LSU) ? p1_req_addr : p0_req_addr;
        data_q  <= (grant == PORT_LSU) ? p1_req_data : p0_req_data;
        mask_q  <= (grant == PORT_LSU) ? p1_req_mask : p0_req_mask;
      end
      if (capture) resp_data_q <= c_resp_data;
    end
  end

  assign c_req_addr   = addr_q;
  assign c_req_data   = data_q;
  assign c_req_mask   = mask_q;
  assign p0_resp_data = resp_data_q;
  assign p1_resp_data = resp_data_q;

`ifndef SYNTHESIS
  a_p0_valid_held: assert property (@(posedge clk) disable iff (rst)
    (p0_req_valid && !p0_req_ready) |=> p0_req_valid);
  a_p1_valid_held: assert property (@(posedge clk) disable iff (rst)
    (p1_req_valid && !p1_req_ready) |=> p1_req_valid);
  a_one_ready: assert property (@(posedge clk) disable iff (rst)
    !(p0_req_ready && p1_req_ready));
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter with a level-style cache model; expectations follow
// the round-robin build when CACHE_ARB_RR_EN is defined, fixed priority otherwise.
module tb_cache_arbiter;
  import cache_arbiter_pkg::*;

`ifdef CACHE_ARB_RR_EN
  localparam logic       TB_RR_INIT  = 1'b0;
  localparam logic [3:0] EXP_GRANTS  = 4'b1010;
`else
  localparam logic       TB_RR_INIT  = 1'b1;
  localparam logic [3:0] EXP_GRANTS  = 4'b1111;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              p0_req_valid = 1'b0, p1_req_valid = 1'b0;
  logic              p0_req_ready, p1_req_ready;
  logic [WIDTH-1:0]  p0_req_addr = '0, p0_req_data = '0, p1_req_addr = '0, p1_req_data = '0;
  logic [MASK_W-1:0] p0_req_mask = '0, p1_req_mask = '0;
  logic              p0_resp_valid, p1_resp_valid;
  logic [WIDTH-1:0]  p0_resp_data, p1_resp_data;
  logic              c_req_valid, c_resp_valid;
  logic [WIDTH-1:0]  c_req_addr, c_req_data, c_resp_data;
  logic [MASK_W-1:0] c_req_mask;

  cache_arbiter #(.RR_INIT(TB_RR_INIT)) dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
    .p0_req_addr(p0_req_addr), .p0_req_data(p0_req_data), .p0_req_mask(p0_req_mask),
    .p0_resp_valid(p0_resp_valid), .p0_resp_data(p0_resp_data),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
    .p1_req_addr(p1_req_addr), .p1_req_data(p1_req_data), .p1_req_mask(p1_req_mask),
    .p1_resp_valid(p1_resp_valid), .p1_resp_data(p1_resp_data),
    .c_req_valid(c_req_valid), .c_req_addr(c_req_addr), .c_req_data(c_req_data),
    .c_req_mask(c_req_mask), .c_resp_valid(c_resp_valid), .c_resp_data(c_resp_data)
  );

  always #5 clk = ~clk;

  // Cache model: idle level drops the cycle after a request and returns after lat_cfg cycles.
  int         lat_cfg     = 1;
  logic [31:0] rdata_cfg  = '0;
  logic       stall_force = 1'b0;
  int         busy_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst)               busy_cnt <= 0;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    else if (c_req_valid)  busy_cnt <= lat_cfg;
  end
  assign c_resp_valid = (busy_cnt == 0) && !stall_force;
  assign c_resp_data  = rdata_cfg;

  // Monitor
  int               cyc = 0, p0_resp_cnt = 0, p1_resp_cnt = 0, p0_resp_cyc = 0, p1_resp_cyc = 0;
  int               creq_cnt = 0, creq_double = 0, field_err = 0;
  logic             prev_creq = 1'b0;
  logic [WIDTH-1:0] p0_last = '0, p1_last = '0;
  logic             track = 1'b0;
  logic [WIDTH-1:0] exp_addr = '0, exp_data = '0;
  logic [MASK_W-1:0] exp_mask = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (p0_resp_valid) begin p0_resp_cnt <= p0_resp_cnt + 1; p0_last <= p0_resp_data; p0_resp_cyc <= cyc; end
    if (p1_resp_valid) begin p1_resp_cnt <= p1_resp_cnt + 1; p1_last <= p1_resp_data; p1_resp_cyc <= cyc; end
    if (c_req_valid) creq_cnt <= creq_cnt + 1;
    if (c_req_valid && prev_creq) creq_double <= creq_double + 1;
    prev_creq <= c_req_valid;
    if (track && (c_req_addr !== exp_addr || c_req_data !== exp_data || c_req_mask !== exp_mask))
      field_err <= field_err + 1;
  end

  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic start_req(input logic port, input logic [WIDTH-1:0] addr, data,
                           input logic [MASK_W-1:0] mask, output int acc_cyc);
    @(posedge clk); #1;
    if (port) begin p1_req_valid = 1'b1; p1_req_addr = addr; p1_req_data = data; p1_req_mask = mask; end
    else      begin p0_req_valid = 1'b1; p0_req_addr = addr; p0_req_data = data; p0_req_mask = mask; end
    acc_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (port ? p1_req_ready : p0_req_ready) begin acc_cyc = cyc; break; end
    end
    check("accept", port ? p1_req_ready : p0_req_ready, 1);
    @(posedge clk); #1;
    if (port) p1_req_valid = 1'b0; else p0_req_valid = 1'b0;
  endtask

  task automatic wait_resp(input logic port, input int start, input int max_cyc, output int resp_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk); #1;
      if ((port ? p1_resp_cnt : p0_resp_cnt) != start) break;
    end
    repeat (3) @(negedge clk);
    #1;
    check(port ? "p1_resp_once" : "p0_resp_once", (port ? p1_resp_cnt : p0_resp_cnt) - start, 1);
    resp_cyc = port ? p1_resp_cyc : p0_resp_cyc;
  endtask

  // Hold both ports valid; each port drops valid once it is accepted after the n-th grant.
  task automatic run_grants(input int n, input logic [3:0] exp_bits);
    logic [3:0] got;
    logic       who;
    int         k;
    got = '0;
    k   = 0;
    lat_cfg = 1;
    @(posedge clk); #1;
    p0_req_valid = 1'b1; p0_req_addr = 32'h100; p0_req_mask = '0;
    p1_req_valid = 1'b1; p1_req_addr = 32'h104; p1_req_mask = '0;
    for (int i = 0; i < 400 && (p0_req_valid || p1_req_valid); i++) begin
      @(negedge clk);
      if (p0_req_ready || p1_req_ready) begin
        who = p1_req_ready;
        if (k < 4) got[k] = who;
        k++;
        @(posedge clk); #1;
        if (k >= n) begin
          if (who) p1_req_valid = 1'b0; else p0_req_valid = 1'b0;
        end
      end
    end
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    check("grant_count", k, n + 1);
    for (int i = 0; i < n; i++) check($sformatf("grant%0d", i), got[i], exp_bits[i]);
    repeat (10) @(posedge clk);
  endtask

  int acc, rc, c0, c1, q0;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_c_req_valid", c_req_valid, 0);
    check("rst_p0_resp_valid", p0_resp_valid, 0);
    check("rst_p1_resp_valid", p1_resp_valid, 0);
    check("rst_c_req_addr", c_req_addr, 0);
    check("rst_c_req_mask", c_req_mask, 0);
    check("rst_resp_data", p0_resp_data, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("idle_ready", {p1_req_ready, p0_req_ready}, 0);

    // Single read, 5 busy cycles: resp 8 cycles after accept
    lat_cfg = 5; rdata_cfg = 32'hDEADBEEF;
    c0 = p0_resp_cnt; c1 = p1_resp_cnt; q0 = creq_cnt;
    start_req(1'b0, 32'h0000_1004, 32'h0, 4'h0, acc);
    check("rd_c_req_addr", c_req_addr, 32'h0000_1004);
    wait_resp(1'b0, c0, 60, rc);
    check("rd_data", p0_last, 32'hDEADBEEF);
    check("rd_latency", rc - acc, 8);
    check("rd_creq_once", creq_cnt - q0, 1);
    check("rd_p1_quiet", p1_resp_cnt - c1, 0);

    // Fastest cache: resp at T+4
    lat_cfg = 1; rdata_cfg = 32'hCAFEF00D;
    c1 = p1_resp_cnt;
    start_req(1'b1, 32'h0000_0080, 32'h0, 4'h0, acc);
    wait_resp(1'b1, c1, 60, rc);
    check("min_latency", rc - acc, 4);
    check("min_data", p1_last, 32'hCAFEF00D);

    // Long dirty refill on a p1 write: request fields must not move
    lat_cfg = 1100; rdata_cfg = 32'h0;
    exp_addr = 32'h40; exp_data = 32'h1234_5678; exp_mask = 4'b1111;
    c0 = p0_resp_cnt; c1 = p1_resp_cnt; q0 = creq_cnt;
    start_req(1'b1, 32'h40, 32'h1234_5678, 4'b1111, acc);
    track = 1'b1;
    wait_resp(1'b1, c1, 1300, rc);
    track = 1'b0;
    check("wr_fields_stable", field_err, 0);
    check("wr_c_req_data", c_req_data, 32'h1234_5678);
    check("wr_latency", rc - acc, 1103);
    check("wr_creq_once", creq_cnt - q0, 1);
    check("wr_p0_quiet", p0_resp_cnt - c0, 0);

    // Cache not idle at issue for 3 cycles
    lat_cfg = 2; rdata_cfg = 32'h0BAD_F00D;
    stall_force = 1'b1;
    c0 = p0_resp_cnt;
    start_req(1'b0, 32'h200, 32'h0, 4'h0, acc);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall_creq%0d", i), c_req_valid, 0);
    end
    @(posedge clk); #1 stall_force = 1'b0;
    @(negedge clk);
    check("stall_release_creq", c_req_valid, 1);
    wait_resp(1'b0, c0, 60, rc);
    check("stall_data", p0_last, 32'h0BAD_F00D);

    // Contention from a fresh reset
    do_reset();
    run_grants(4, EXP_GRANTS);

    // Reset during A_BUSY
    do_reset();
    lat_cfg = 1;
    c0 = p0_resp_cnt;
    start_req(1'b0, 32'h10, 32'h0, 4'h0, acc);
    wait_resp(1'b0, c0, 60, rc);
    lat_cfg = 30;
    c1 = p1_resp_cnt;
    start_req(1'b1, 32'h300, 32'hA5A5_A5A5, 4'b0011, acc);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort_c_req_valid", c_req_valid, 0);
    check("abort_resp_valid", {p1_resp_valid, p0_resp_valid}, 0);
    check("abort_c_req_addr", c_req_addr, 0);
    check("abort_c_req_data", c_req_data, 0);
    check("abort_c_req_mask", c_req_mask, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    check("abort_no_pulse", p1_resp_cnt - c1, 0);
    run_grants(1, {3'b000, TB_RR_INIT});

    check("creq_never_back2back", creq_double, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
